// File: rtl/pair_bit_serializer.sv
// pair_bit_serializer: accepts a WIDTH-bit word over valid/ready and streams it
// out two bits per cycle on x_out/y_out to feed a mod-6 ones-counting FSM.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    upstream word valid
//   in_ready    block can accept a word this cycle (IDLE or DONE)
//   in_data     word to serialize
//   x_out       pair bit A (to counter X_in), 0 outside a frame
//   y_out       pair bit B (to counter Y_in), 0 outside a frame
//   busy        frame in progress
//   frame_done  one-cycle pulse once the last pair has been absorbed downstream
//   ones_count  (only with PAIR_SERIALIZER_ONES_COUNT_EN) ones sent in the frame
//
// Optional feature: define PAIR_SERIALIZER_ONES_COUNT_EN to add ones_count.
module pair_bit_serializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x_out,
    output logic             y_out,
    output logic             busy,
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] ones_count,
`endif
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH / 2 + 1);

    if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_width_check
        $error("pair_bit_serializer: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             capture;

    // DONE accepts a new word too, giving back-to-back frames without a bubble.
    assign in_ready = (state != SHIFT);
    assign capture  = in_valid & in_ready;
    assign x_out    = (state == SHIFT) & (LSB_FIRST ? sreg[1] : sreg[WIDTH-1]);
    assign y_out    = (state == SHIFT) & (LSB_FIRST ? sreg[0] : sreg[WIDTH-2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    sreg <= LSB_FIRST ? (sreg >> 2) : (sreg << 2);
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    frame_done <= 1'b0;
                    if (capture) begin
                        sreg  <= in_data;
                        cnt   <= CW'(WIDTH / 2);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
    localparam int OW = $clog2(WIDTH + 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ones_count <= '0;
        else if (capture)
            ones_count <= '0;
        else if (state == SHIFT)
            ones_count <= ones_count + OW'(x_out) + OW'(y_out);
    end
`endif
endmodule

// File: tb/tb_pair_bit_serializer.sv
// tb_pair_bit_serializer: scoreboard bench driving an MSB-first and an
// LSB-first instance (WIDTH=8) with directed and random words.
module tb_pair_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         xo[2], yo[2], bs[2], fd[2], rdy[2];
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
    logic [3:0]   oc[2];
    int           hold_ones = -1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] ex;
        logic [1:0] ey;
        bit         done;
        int         ones;
    } ent_t;

    ent_t q[$];
    ent_t e;
    bit   took_pair;

    always #5 clk = ~clk;

    pair_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .x_out(xo[0]), .y_out(yo[0]), .busy(bs[0]),
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
        .ones_count(oc[0]),
`endif
        .frame_done(fd[0])
    );

    pair_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .x_out(xo[1]), .y_out(yo[1]), .busy(bs[1]),
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
        .ones_count(oc[1]),
`endif
        .frame_done(fd[1])
    );

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, i, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_x"}, i, 32'(xo[i]), 0);
            chk({tag, "_y"}, i, 32'(yo[i]), 0);
            chk({tag, "_busy"}, i, 32'(bs[i]), 0);
            chk({tag, "_done"}, i, 32'(fd[i]), 0);
            chk({tag, "_ready"}, i, 32'(rdy[i]), 1);
        end
    endtask

    // Reference: a captured word becomes W/2 pair cycles followed by one done cycle.
    function automatic void push_word(input logic [W-1:0] w);
        ent_t n;
        for (int k = 0; k < W / 2; k++) begin
            n.ex   = {w[2*k+1], w[W-1-2*k]};
            n.ey   = {w[2*k],   w[W-2-2*k]};
            n.done = 1'b0;
            n.ones = 0;
            q.push_back(n);
        end
        n.ex   = 2'b00;
        n.ey   = 2'b00;
        n.done = 1'b1;
        n.ones = $countones(w);
        q.push_back(n);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
            hold_ones = -1;
`endif
            chk_idle("rst");
        end else begin
            took_pair = 1'b0;
            if (q.size() > 0) begin
                e = q.pop_front();
                took_pair = !e.done;
                for (int i = 0; i < 2; i++) begin
                    chk("x", i, 32'(xo[i]), 32'(e.ex[i]));
                    chk("y", i, 32'(yo[i]), 32'(e.ey[i]));
                    chk("busy", i, 32'(bs[i]), 32'(!e.done));
                    chk("frame_done", i, 32'(fd[i]), 32'(e.done));
                    chk("in_ready", i, 32'(rdy[i]), 32'(e.done));
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
                    if (e.done) chk("ones_count", i, 32'(oc[i]), 32'(e.ones));
`endif
                end
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
                if (e.done) hold_ones = e.ones;
`endif
            end else begin
                chk_idle("idle");
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
                if (hold_ones >= 0)
                    for (int i = 0; i < 2; i++) chk("ones_hold", i, 32'(oc[i]), 32'(hold_ones));
`endif
            end
            if (in_valid && !took_pair) begin
                push_word(in_data);
`ifdef PAIR_SERIALIZER_ONES_COUNT_EN
                hold_ones = -1;
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step(1);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        step(1);
        send(8'hFF);
        step(6);
        send(8'h3C);
        step(6);
        send(8'hA8);
        step(6);
        // back-to-back: FC captured now, 03 captured in FC's DONE cycle
        in_valid = 1'b1;
        in_data  = 8'hFC;
        step(1);
        in_data  = 8'h03;
        step(5);
        in_valid = 1'b0;
        step(7);
        // asynchronous reset in cycle 2 of an FF frame
        send(8'hFF);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_idle("async_rst");
        step(1);
        reset = 1'b0;
        step(6);
        // 55 offered during the 0F frame is ignored
        send(8'h0F);
        step(1);
        send(8'h55);
        step(6);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                in_valid = 1'b0;
                reset    = 1'b1;
                step(1);
                reset    = 1'b0;
            end else begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = W'($urandom);
                step(1);
            end
        end
        in_valid = 1'b0;
        for (int t = 0; t < 40 && q.size() > 0; t++) step(1);
        chk("drain", 0, 32'(q.size()), 0);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pair_bit_serializer.md
Name: pair_bit_serializer

Overview:
Upstream feeder for the mod-6 ones-counting FSM. The block accepts a parallel WIDTH-bit word over a valid/ready handshake and streams it out two bits per cycle on x_out/y_out. These outputs drive the counter's X_in/Y_in directly. x_out/y_out are held at 0 when no frame is active, so the downstream count is unaffected between frames. A one-cycle frame_done pulse marks the cycle in which the downstream divisable output reflects the complete word.

Parameters:
- WIDTH, 16, input word width. Must be even and ≥ 2; non-even values are an elaboration error.
- LSB_FIRST, 0, pair order. 0: first pair is {bit WIDTH-1, bit WIDTH-2}. 1: first pair is {bit 1, bit 0}.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  word to serialize
- x_out  out  1  pair bit A, to counter X_in
- y_out  out  1  pair bit B, to counter Y_in
- busy  out  1  frame in progress (SHIFT state)
- frame_done  out  1  one-cycle pulse: last pair absorbed downstream

Behaviour:
- Reset is asserted on reset, asynchronous, active-high. Clock is clk.
- Reset values: state IDLE; shift register 0; pair counter 0; x_out=0, y_out=0, busy=0, frame_done=0, in_ready=1 (combinational from IDLE).
- FSM states:
  - IDLE
    - in_ready=1.
    - If in_valid: load in_data, set pair counter to WIDTH/2, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT
    - in_ready=0, busy=1.
    - x_out/y_out present the current pair combinationally from the shift register head. LSB_FIRST=0: x=sreg[WIDTH-1], y=sreg[WIDTH-2]. LSB_FIRST=1: x=sreg[1], y=sreg[0].
    - Each cycle: shift by 2 (left for MSB-first, right for LSB-first, zero fill) and decrement the counter.
    - When the counter equals 1, go to DONE.
  - DONE
    - frame_done=1 for exactly this cycle. x_out=y_out=0, in_ready=1.
    - If in_valid: load the new word and go to SHIFT (back-to-back frames, no bubble).
    - Otherwise go to IDLE.
- Outside SHIFT, x_out and y_out are forced to 0. The downstream FSM therefore holds its state.
- Timing:
  - Handshake at edge E0 (in_valid & in_ready).
  - Pairs are driven in cycles 1..WIDTH/2.
  - frame_done is high in cycle WIDTH/2+1, the first cycle in which the downstream state includes all pairs.
  - Per-frame throughput: WIDTH/2+1 cycles.
- Handshake rules:
  - in_data is sampled only on in_valid & in_ready.
  - in_valid while in SHIFT is ignored; no capture, no error.
  - in_data changes during SHIFT have no effect.
- Reset mid-frame: the block returns to IDLE immediately and outputs go to their reset values. The partial frame is discarded with no frame_done. The downstream counter shares the same reset.
- Simultaneous DONE and in_valid: frame_done pulse and capture happen in the same cycle. The next frame's first pair appears the following cycle.

Optional Feature:
- Macro: PAIR_SERIALIZER_ONES_COUNT_EN.
- Defined:
  - Adds output ones_count, width $clog2(WIDTH+1).
  - Cleared on reset and on each capture.
  - Adds x_out+y_out every SHIFT cycle.
  - Valid and stable from the frame_done cycle until the next capture. The bench uses it as a golden reference for the downstream divisable (ones_count % 6 == 0).
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, LSB_FIRST=0, reset then in_data=8'hFF with in_valid for 1 cycle -> (x,y)=(1,1) in cycles 1-4. frame_done in cycle 5. ones_count=8. Downstream divisable=0.
- in_data=8'h3C -> pairs 00,11,11,00. frame_done in cycle 5. ones_count=4.
- in_data=8'hA8 with LSB_FIRST=1 -> pairs (y,x order bits[1:0] first) 00,10,10,10 => (x,y)=(0,0),(1,0),(1,0),(1,0). ones_count=3.
- Back-to-back: in_valid held high with 8'hFC then 8'h03. Second word is captured in the DONE cycle of the first. First pair of the second word is in cycle 6. frame_done pulses in cycles 5 and 10. Downstream divisable=1 at cycle 5 (6 ones); cumulative count is 8 at cycle 10, so divisable=0.
- Reset asserted in cycle 2 of an 8'hFF frame -> x_out=y_out=0, busy=0, in_ready=1 immediately. No frame_done follows.
- in_valid pulsed with 8'h55 during SHIFT of 8'h0F -> ignored. Only one frame_done. ones_count=4.
